// File: rtl/pulsador_repeticion_pkg.sv
// pulsador_repeticion_pkg
// Shared definitions for the push-button pulse/auto-repeat block:
//   - canal_state_e : per-channel FSM state encoding (2 bits)
//   - BTN_*         : bit positions of each button on the 4-bit bus
//   - max_u         : elaboration-time helper used to size the counters
package pulsador_repeticion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HOLD = 2'd1,
        ST_REPEAT    = 2'd2
    } canal_state_e;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    localparam int unsigned NUM_BTN = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulsador_repeticion_if.sv
// pulsador_repeticion_if
// Button bus between the debouncer (master side) and the pulse generator
// (slave side).
//   btn_db    : debounced button levels, [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
//   btn_pulse : one-cycle command pulse per channel
//   btn_held  : high while a channel is auto-repeating
interface pulsador_repeticion_if;

    logic [3:0] btn_db;
    logic [3:0] btn_pulse;
    logic [3:0] btn_held;

    modport master (
        output btn_db,
        input  btn_pulse,
        input  btn_held
    );

    modport slave (
        input  btn_db,
        output btn_pulse,
        output btn_held
    );

endinterface

// File: rtl/pulsador_canal.sv
// pulsador_canal
// Single button channel: turns a debounced level into a press pulse and,
// when REPEAT_ON is set, typematic repeat pulses while the button stays down.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset
//   btn   : debounced level of this button
//   pulse : registered one-cycle command pulse
//   held  : registered, high while the channel is in auto-repeat
module pulsador_canal
    import pulsador_repeticion_pkg::*;
#(
    parameter int unsigned HOLD_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD = 12500000,
    parameter bit          REPEAT_ON     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse,
    output logic held
);

    localparam int unsigned CNT_MAX = max_u(HOLD_DELAY, REPEAT_PERIOD);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counter values on the edge that issues the next pulse.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    canal_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_q;
    logic             pulse_q;
    logic             held_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            // Treat the button as already down so a held button cannot fire
            // as soon as reset is released.
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            prev_q  <= btn;
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q  <= '0;
                    held_q <= 1'b0;
                    if (btn && !prev_q) begin
                        pulse_q <= 1'b1;
                        if (REPEAT_ON) begin
                            state_q <= ST_WAIT_HOLD;
                        end
                    end
                end
                ST_WAIT_HOLD: begin
                    if (!btn) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else if (cnt_q == HOLD_LAST) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                        state_q <= ST_REPEAT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    // Release is checked first so it beats a coincident repeat.
                    if (!btn) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else if (cnt_q == REP_LAST) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        held_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// File: rtl/pulsador_repeticion.sv
// pulsador_repeticion
// Converts the four debounced button levels into command pulses with
// per-channel auto-repeat, for the clock/timer configuration FSM.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : button bus (slave side): btn_db in, btn_pulse / btn_held out
module pulsador_repeticion
    import pulsador_repeticion_pkg::*;
#(
    parameter int unsigned HOLD_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD = 12500000,
    parameter logic [3:0]  REPEAT_EN     = 4'b0011
) (
    input  logic                         clk,
    input  logic                         reset,
    pulsador_repeticion_if.slave         bus
);

    logic [NUM_BTN-1:0] pulse_w;
    logic [NUM_BTN-1:0] held_w;

    // Channels are fully independent; no priority between buttons.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_canal
        pulsador_canal #(
            .HOLD_DELAY    (HOLD_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_ON     (REPEAT_EN[i])
        ) u_canal (
            .clk   (clk),
            .reset (reset),
            .btn   (bus.btn_db[i]),
            .pulse (pulse_w[i]),
            .held  (held_w[i])
        );
    end

    assign bus.btn_pulse = pulse_w;
    assign bus.btn_held  = held_w;

endmodule

// File: tb/tb_pulsador_repeticion.sv
// tb_pulsador_repeticion
// Bench for pulsador_repeticion with HOLD_DELAY=10, REPEAT_PERIOD=4,
// REPEAT_EN=4'b0011. A timing model derives expected outputs from the
// press time of each channel; directed scenarios add literal expectations.
module tb_pulsador_repeticion;

    localparam int unsigned H   = 10;
    localparam int unsigned P   = 4;
    localparam logic [3:0]  REN = 4'b0011;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pulsador_repeticion_if bus ();

    pulsador_repeticion #(
        .HOLD_DELAY    (H),
        .REPEAT_PERIOD (P),
        .REPEAT_EN     (REN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model state: cycle index, press time per channel, whether the channel
    // is still in its hold/repeat run.
    int         cyc = 0;
    logic [3:0] m_prev;
    logic [3:0] exp_pulse = '0;
    logic [3:0] exp_held  = '0;
    bit         m_active [4];
    int         m_t0     [4];
    logic [3:0] ren_v = REN;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            exp_pulse = '0;
            exp_held  = '0;
            m_prev    = 4'hF;
            for (int i = 0; i < 4; i++) m_active[i] = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic b;
                int   d;
                b            = bus.btn_db[i];
                exp_pulse[i] = 1'b0;
                exp_held[i]  = 1'b0;
                if (b && !m_prev[i]) begin
                    exp_pulse[i] = 1'b1;
                    m_t0[i]      = cyc;
                    m_active[i]  = ren_v[i];
                end else if (b && m_active[i]) begin
                    d            = cyc - m_t0[i];
                    exp_pulse[i] = (d >= int'(H)) && (((d - int'(H)) % int'(P)) == 0);
                    exp_held[i]  = (d >= int'(H));
                end else begin
                    m_active[i] = 1'b0;
                end
                m_prev[i] = b;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model pulse", 64'(bus.btn_pulse), 64'(exp_pulse));
            check("model held", 64'(bus.btn_held), 64'(exp_held));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [63:0] seen;
        logic [63:0] want;
        int          cnt;
        int          first;
        bit          held_seen;

        bus.btn_db = 4'h0;
        reset      = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        tick();
        check("reset pulse", 64'(bus.btn_pulse), 64'h0);
        check("reset held", 64'(bus.btn_held), 64'h0);
        tick(3);
        reset = 1'b1;
        tick(5);

        // 1: UP held, press pulse then repeats at +10, +14, ...
        seen = '0;
        want = '0;
        want[1] = 1'b1;
        for (int k = 11; k <= 31; k += 4) want[k] = 1'b1;
        bus.btn_db = 4'b0001;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.btn_pulse[0]) seen[k] = 1'b1;
            if (k == 10) check("up held before hold", 64'(bus.btn_held), 64'h0);
            if (k == 11) check("up held at first repeat", 64'(bus.btn_held), 64'h1);
            if (k == 31) begin
                check("up held late", 64'(bus.btn_held), 64'h1);
                bus.btn_db = 4'b0000;
            end
            if (k == 32) check("up held after release", 64'(bus.btn_held), 64'h0);
        end
        check("up pulse times", seen, want);
        tick(3);

        // 2: LEFT has no repeat, single pulse only
        cnt        = 0;
        first      = -1;
        held_seen  = 1'b0;
        bus.btn_db = 4'b0100;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.btn_pulse[2]) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (bus.btn_held[2]) held_seen = 1'b1;
        end
        bus.btn_db = 4'b0000;
        tick(3);
        check("left pulse count", 64'(cnt), 64'd1);
        check("left pulse latency", 64'(first), 64'd1);
        check("left held", 64'(held_seen), 64'd0);

        // 3: UP and RIGHT together, RIGHT released early
        bus.btn_db = 4'b1001;
        tick();
        check("simultaneous pulse", 64'(bus.btn_pulse), 64'h9);
        tick(2);
        bus.btn_db = 4'b0001;
        for (int k = 4; k <= 11; k++) begin
            tick();
            if (k == 10) check("up no early repeat", 64'(bus.btn_pulse), 64'h0);
        end
        check("up repeat with right released", 64'(bus.btn_pulse), 64'h1);
        check("up held with right released", 64'(bus.btn_held), 64'h1);
        bus.btn_db = 4'b0000;
        tick(3);

        // 4: DOWN held through reset must be released before firing again
        bus.btn_db = 4'b0010;
        tick(2);
        reset = 1'b0;
        tick();
        check("mid reset pulse", 64'(bus.btn_pulse), 64'h0);
        tick();
        reset = 1'b1;
        cnt   = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.btn_pulse != 4'h0) cnt++;
        end
        check("held through reset no pulse", 64'(cnt), 64'd0);
        bus.btn_db = 4'b0000;
        tick();
        bus.btn_db = 4'b0010;
        tick();
        check("re-press after reset", 64'(bus.btn_pulse), 64'h2);
        bus.btn_db = 4'b0000;
        tick(3);

        // 5: release exactly on the first scheduled repeat edge
        bus.btn_db = 4'b0001;
        tick(9);
        bus.btn_db = 4'b0000;
        tick();
        check("release beats repeat pulse", 64'(bus.btn_pulse), 64'h0);
        check("release beats repeat held", 64'(bus.btn_held), 64'h0);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.btn_pulse != 4'h0) cnt++;
        end
        check("silent after release", 64'(cnt), 64'd0);

        // 6: one-cycle glitch, one low cycle, press again
        bus.btn_db = 4'b0010;
        tick();
        check("glitch pulse", 64'(bus.btn_pulse), 64'h2);
        bus.btn_db = 4'b0000;
        tick();
        check("glitch gap", 64'(bus.btn_pulse), 64'h0);
        bus.btn_db = 4'b0010;
        tick();
        check("quick re-press pulse", 64'(bus.btn_pulse), 64'h2);
        bus.btn_db = 4'b0000;
        tick(3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
